pipemdu: RTL and testbench
==========================

Name: pipemdu

Overview:
Iterative multiply/divide unit that serves MULT/MULTU/DIV/DIVU requests issued by the pipelined CPU's EXE stage. It owns the HI/LO registers and handles MTHI/MTLO writes and MFHI/MFLO reads. It returns results through a start/busy/done handshake plus a stall request to the pipeline control. One operation is in flight at a time, and it takes 32 iterations plus 1 fix-up cycle.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  EXE stage issues a mul/div op this cycle.
eop  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
ea  input  WIDTH  rs operand: multiplicand/dividend; also the data for MTHI/MTLO.
eb  input  WIDTH  rt operand: multiplier/divisor.
ewhi  input  1  MTHI: write ea into HI.
ewlo  input  1  MTLO: write ea into LO.
erhilo  input  1  MFHI or MFLO present in EXE.
hi  output  WIDTH  HI register: upper product or remainder.
lo  output  WIDTH  LO register: lower product or quotient.
busy  output  1  an operation is in progress.
done  output  1  one-cycle pulse; HI/LO were just updated by an op.
stall  output  1  freezes PC, IF/ID and ID/EXE; combinational.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset applied mid-operation aborts the op, and the partial result is discarded.
- State machine: IDLE -> CALC -> FIX -> IDLE. busy = (state != IDLE), registered.
- IDLE, start=1 at edge 0:
  - Latch the operands. For signed ops, convert both operands to magnitudes and record the result sign (and the remainder sign for DIV, which equals the dividend sign).
  - Clear the counter and go to CALC.
  - start has priority over ewhi/ewlo in the same cycle; the MTHI/MTLO is dropped.
- CALC, edges 1..32, one iteration per edge:
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - After the 32nd iteration, go to FIX.
- FIX, edge 33:
  - Apply two's-complement sign fix-up to the product, or to the quotient and remainder.
  - Write hi/lo, set done=1 for exactly one cycle, and return to IDLE.
  - busy is high for 33 cycles (after edges 0..32); hi/lo hold the new result after edge 33.
- Result mapping:
  - Multiply: hi=product[63:32], lo=product[31:0].
  - Divide: lo=quotient, hi=remainder. The remainder takes the dividend's sign, and the quotient truncates toward zero.
- Divide by zero (eb=0, DIV or DIVU): lo=32'hFFFFFFFF, hi=ea as latched. Latency is unchanged (still 33 cycles).
- Signed overflow (DIV 32'h80000000 by 32'hFFFFFFFF): lo=32'h80000000, hi=0.
- start while busy: ignored, with no effect on the op in progress.
- ewhi/ewlo while busy: ignored.
- stall = busy & (start | erhilo | ewhi | ewlo). The pipeline holds the instruction until busy drops, then reissues it.
- MTHI/MTLO in IDLE with start=0: hi and/or lo <= ea at the edge; done stays 0. ewhi and ewlo may be asserted together.
- hi/lo are directly readable at all times. During CALC they hold their pre-op values; only FIX, MTHI/MTLO and reset change them.

Test Plan:
- Reset, then MULTU ea=32'hFFFFFFFF, eb=32'hFFFFFFFF -> busy for 33 cycles; after edge 33 hi=32'hFFFFFFFE, lo=32'h00000001; done high for exactly 1 cycle.
- MULT ea=-3 (32'hFFFFFFFD), eb=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
- DIV ea=-7, eb=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIVU ea=32'h12345678, eb=0 -> lo=32'hFFFFFFFF, hi=32'h12345678 after 33 cycles.
- DIV ea=32'h80000000, eb=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- Hazards and control:
  - During an op, pulse start with different operands, then erhilo, then ewhi: stall=1 in each of those cycles, and the in-flight result is unaffected.
  - Assert reset at cycle 10 of a divide: next cycle busy=0, hi=lo=0, and done never pulses.
  - In IDLE, assert ewhi=ewlo=1 with ea=32'hA5A5A5A5: both hi and lo become 32'hA5A5A5A5, and stall stays 0.

Source files
------------

// File: rtl/pipemdu_if.sv
// Request/result bundle between the EXE stage and the multiply/divide unit.
// The CPU side is the master and the MDU is the slave.
interface pipemdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       eop;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic             ewhi;
    logic             ewlo;
    logic             erhilo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, eop, ea, eb, ewhi, ewlo, erhilo,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, eop, ea, eb, ewhi, ewlo, erhilo,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/pipemdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: WIDTH shift iterations then
// one sign fix-up cycle, with a stall request while an op is in flight.
module pipemdu #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clock,
    input logic       reset,
    pipemdu_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;
    logic             busy_q;
    logic             done_q;

    logic             last_c;
    logic             sgn_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_trial_c;
    logic [AW-1:0]    acc_nxt_c;
    logic [AW-1:0]    prod_c;
    logic [WIDTH-1:0] quo_c;
    logic [WIDTH-1:0] rem_c;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        last_c  = (cnt == CW'(WIDTH - 1));
        case (state)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (last_c) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes and sign bookkeeping for signed ops
    always_comb begin
        sgn_c   = ~bus.eop[0];
        a_neg_c = sgn_c & bus.ea[WIDTH-1];
        b_neg_c = sgn_c & bus.eb[WIDTH-1];
        mag_a_c = a_neg_c ? -bus.ea : bus.ea;
        mag_b_c = b_neg_c ? -bus.eb : bus.eb;
    end

    // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum_c   = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_trial_c = {acc[AW-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        if (is_div) begin
            if (div_trial_c[WIDTH]) begin
                acc_nxt_c = {acc[AW-2:0], 1'b0};
            end else begin
                acc_nxt_c = {div_trial_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_nxt_c = {mul_sum_c, acc[WIDTH-1:1]};
        end
    end

    // Two's-complement fix-up of the magnitude result
    always_comb begin
        prod_c = neg_res ? -acc : acc;
        quo_c  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_c  = neg_rem ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
    end

    // Datapath, HI/LO and handshake registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // a pending MTHI/MTLO in the same cycle loses to start
                        cnt      <= '0;
                        is_div   <= bus.eop[1];
                        neg_res  <= a_neg_c ^ b_neg_c;
                        neg_rem  <= a_neg_c;
                        div_zero <= (bus.eb == '0);
                        a_raw    <= bus.ea;
                        opnd     <= bus.eop[1] ? mag_b_c : mag_a_c;
                        acc      <= {WIDTH'(0), (bus.eop[1] ? mag_a_c : mag_b_c)};
                    end else begin
                        if (bus.ewhi) hi_q <= bus.ea;
                        if (bus.ewlo) lo_q <= bus.ea;
                    end
                end
                CALC: begin
                    acc <= acc_nxt_c;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (!is_div) begin
                        hi_q <= prod_c[AW-1:WIDTH];
                        lo_q <= prod_c[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi_q <= a_raw;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_c;
                        lo_q <= quo_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = busy_q & (bus.start | bus.erhilo | bus.ewhi | bus.ewlo);
endmodule

// File: tb/tb_pipemdu.sv
// Directed bench for pipemdu: expected HI/LO pushed at issue, popped on done.
module tb_pipemdu;
    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   edges;
    int   busy_cnt;
    exp_t sb[$];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    pipemdu_if #(.WIDTH(W)) bus ();
    pipemdu #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        edges++;
        if (bus.busy) busy_cnt++;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] xhi, input logic [W-1:0] xlo);
        exp_t e;
        bus.start = 1'b1;
        bus.eop   = op;
        bus.ea    = a;
        bus.eb    = b;
        e.hi = xhi;
        e.lo = xlo;
        sb.push_back(e);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.ewhi  = 1'b0;
        bus.ewlo  = 1'b0;
        edges    = 0;
        busy_cnt = bus.busy ? 1 : 0;
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        while (!bus.done && edges < 60) begin
            if (edges == 16) check({tag, "_hold"}, {bus.hi, bus.lo}, {m_hi, m_lo});
            tick();
        end
        check({tag, "_latency"}, 64'(edges), 64'd33);
        check({tag, "_busycycles"}, 64'(busy_cnt), 64'd33);
        check({tag, "_sbnotempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_hilo"}, {bus.hi, bus.lo}, {e.hi, e.lo});
            m_hi = e.hi;
            m_lo = e.lo;
        end
        check({tag, "_busyoff"}, 64'(bus.busy), 64'd0);
        tick();
        check({tag, "_donepulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [63:0]  rp;
        int           dcount;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.eop    = 2'b00;
        bus.ea     = '0;
        bus.eb     = '0;
        bus.ewhi   = 1'b0;
        bus.ewlo   = 1'b0;
        bus.erhilo = 1'b0;
        edges      = 0;
        busy_cnt   = 0;
        m_hi       = '0;
        m_lo       = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);

        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        wait_done("multu_max");

        issue(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        wait_done("mult_neg");

        // DIV -7/2 with hazards injected mid-op
        issue(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        tick();
        tick();
        bus.start = 1'b1;
        bus.eop   = 2'b01;
        bus.ea    = 32'd1234;
        bus.eb    = 32'd99;
        #1;
        check("haz_start_stall", 64'(bus.stall), 64'd1);
        tick();
        bus.start  = 1'b0;
        bus.erhilo = 1'b1;
        #1;
        check("haz_rd_stall", 64'(bus.stall), 64'd1);
        tick();
        bus.erhilo = 1'b0;
        bus.ewhi   = 1'b1;
        bus.ea     = 32'hDEADBEEF;
        #1;
        check("haz_mthi_stall", 64'(bus.stall), 64'd1);
        tick();
        bus.ewhi = 1'b0;
        #1;
        check("haz_nostall", 64'(bus.stall), 64'd0);
        wait_done("div_haz");

        // DIVU by zero issued with MTHI in the same cycle; MTHI must be dropped
        bus.ewhi = 1'b1;
        issue(2'b11, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
        check("start_prio_hi", {bus.hi, bus.lo}, {m_hi, m_lo});
        wait_done("divu_zero");

        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        wait_done("div_ovf");

        issue(2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        wait_done("div_negdivisor");

        issue(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        wait_done("mult_minsq");

        issue(2'b10, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF);
        wait_done("div_zero_zero");

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            rp = 64'(ra) * 64'(rb);
            issue(2'b01, ra, rb, rp[63:32], rp[31:0]);
            wait_done("multu_rand");
            rb = $urandom_range(1, 1000);
            issue(2'b11, ra, rb, ra % rb, ra / rb);
            wait_done("divu_rand");
        end

        // MTHI+MTLO together in IDLE
        bus.ewhi = 1'b1;
        bus.ewlo = 1'b1;
        bus.ea   = 32'hA5A5A5A5;
        #1;
        check("mt_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.ewhi = 1'b0;
        bus.ewlo = 1'b0;
        check("mt_hilo", {bus.hi, bus.lo}, {32'hA5A5A5A5, 32'hA5A5A5A5});
        check("mt_done", 64'(bus.done), 64'd0);
        check("mt_busy", 64'(bus.busy), 64'd0);

        // Reset mid-divide aborts the op
        issue(2'b10, 32'd1000, 32'd7, 32'd6, 32'd142);
        while (edges < 10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) dcount++;
        end
        check("abort_nodone", 64'(dcount), 64'd0);
        check("abort_hilo_after", {bus.hi, bus.lo}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
